// File: rtl/alu_cmd_queue.sv
// Issue queue feeding a combinational ALU: commands are buffered in a FIFO,
// the head is driven to the ALU, and its output is captured in a result register.
module alu_cmd_queue #(
  parameter int w     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [w-1:0]           in_a,
  input  logic [w-1:0]           in_b,
  input  logic [1:0]             in_opcode,
  output logic [w-1:0]           alu_a,
  output logic [w-1:0]           alu_b,
  output logic [1:0]             alu_opcode,
  input  logic [w-1:0]           alu_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [w-1:0]           out_result,
  output logic [1:0]             out_opcode,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [w-1:0]  mem_a_q  [DEPTH];
  logic [w-1:0]  mem_b_q  [DEPTH];
  logic [1:0]    mem_op_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [w-1:0]  out_result_q, out_result_d;
  logic [1:0]    out_opcode_q, out_opcode_d;

  logic not_empty, free, push, pop;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != FULL);
  assign free      = !out_valid_q || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = not_empty && free;

  assign alu_a      = not_empty ? mem_a_q[rd_ptr_q]  : '0;
  assign alu_b      = not_empty ? mem_b_q[rd_ptr_q]  : '0;
  assign alu_opcode = not_empty ? mem_op_q[rd_ptr_q] : '0;

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_opcode = out_opcode_q;
  assign count      = count_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_opcode_d = out_opcode_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      out_result_d = alu_out;
      out_opcode_d = alu_opcode;
      out_valid_d  = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; entries are only observed while count says they are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]  <= in_a;
      mem_b_q[wr_ptr_q]  <= in_b;
      mem_op_q[wr_ptr_q] <= in_opcode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_opcode_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_opcode_q <= out_opcode_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue with an attached combinational ALU and a
// queue-based reference model of command ordering and result retirement.
module tb_alu_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0, in_b = '0;
  logic [1:0] in_opcode = '0;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [1:0] alu_opcode;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic [1:0] out_opcode;
  logic [2:0] count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_cmd_queue #(.w(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_opcode(out_opcode), .count(count)
  );

  // Attached ALU
  always_comb begin
    case (alu_opcode)
      2'b00:   alu_out = alu_a + alu_b;
      2'b10:   alu_out = alu_a - alu_b;
      2'b01:   alu_out = alu_a | alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] res;
  } cmd_t;

  cmd_t       mq[$];
  logic       m_ov = 1'b0;
  logic [7:0] m_res = '0;
  logic [1:0] m_op = '0;

  function automatic logic [7:0] exp_res(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int unsigned s;
    if (op == 2'b00)      s = (int'(a) + int'(b)) % 256;
    else if (op == 2'b10) s = (int'(a) + 256 - int'(b)) % 256;
    else if (op == 2'b01) s = int'(a | b);
    else                  s = int'(a ^ b);
    return s[7:0];
  endfunction

  // Drives one cycle of stimulus, advances the model across the edge, and
  // returns at 1 time unit after the edge for sampling.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic ordy, input logic r, output logic acc);
    cmd_t c;
    in_valid = v; in_a = a; in_b = b; in_opcode = op; out_ready = ordy; rst = r;
    @(posedge clk);
    acc = !r && v && (mq.size() < DEPTH);
    if (r) begin
      mq.delete(); m_ov = 1'b0; m_res = '0; m_op = '0;
    end else begin
      if (mq.size() > 0 && (!m_ov || ordy)) begin
        m_res = mq[0].res; m_op = mq[0].op; m_ov = 1'b1;
        void'(mq.pop_front());
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
      if (acc) begin
        c.a = a; c.b = b; c.op = op; c.res = exp_res(a, b, op);
        mq.push_back(c);
      end
    end
    #1;
    in_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    logic acc;
    cycle(1'b1, 8'hAA, 8'h55, 2'b00, 1'b0, 1'b1, acc);
    n_vec++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (count !== 3'd0)      begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++; if (out_result !== 8'h00) begin n_bad++; $display("FAIL reset_out_result got %h want 00", out_result); end
    n_vec++; if (out_opcode !== 2'b00) begin n_bad++; $display("FAIL reset_out_opcode got %b want 00", out_opcode); end
    n_vec++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin n_bad++; $display("FAIL reset_alu_ab got %h/%h want 00/00", alu_a, alu_b); end
  endtask

  task automatic test_single_add();
    logic acc;
    cycle(1'b1, 8'hF0, 8'h20, 2'b00, 1'b1, 1'b0, acc);
    n_vec++; if (out_valid !== 1'b0 || count !== 3'd1) begin n_bad++; $display("FAIL add_no_fallthrough got v=%b cnt=%0d want v=0 cnt=1", out_valid, count); end
    n_vec++; if (alu_a !== 8'hF0 || alu_b !== 8'h20) begin n_bad++; $display("FAIL add_head got %h/%h want f0/20", alu_a, alu_b); end
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, acc);
    n_vec++; if (out_valid !== 1'b1)   begin n_bad++; $display("FAIL add_valid got %b want 1", out_valid); end
    n_vec++; if (out_result !== 8'h10) begin n_bad++; $display("FAIL add_result got %h want 10", out_result); end
    n_vec++; if (out_opcode !== 2'b00) begin n_bad++; $display("FAIL add_opcode got %b want 00", out_opcode); end
    n_vec++; if (count !== 3'd0)       begin n_bad++; $display("FAIL add_count got %0d want 0", count); end
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, acc);
    n_vec++; if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL add_drop got %b want 0", out_valid); end
    n_vec++; if (out_result !== 8'h10) begin n_bad++; $display("FAIL add_hold got %h want 10", out_result); end
  endtask

  task automatic test_full();
    logic acc;
    logic [2:0] want_cnt [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [7:0] held;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, 1'b0, acc);
      n_vec++; if (count !== want_cnt[i]) begin n_bad++; $display("FAIL full_fill_count[%0d] got %0d want %0d", i, count, want_cnt[i]); end
    end
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    held = m_res;
    cycle(1'b1, 8'h77, 8'h11, 2'b00, 1'b0, 1'b0, acc);
    n_vec++; if (count !== 3'd4 || acc !== 1'b0) begin n_bad++; $display("FAIL full_refuse got cnt=%0d want 4", count); end
    n_vec++; if (out_valid !== 1'b1 || out_result !== held) begin n_bad++; $display("FAIL full_stall got v=%b r=%h want v=1 r=%h", out_valid, out_result, held); end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, acc);
      n_vec++;
      if (out_valid !== m_ov || count !== 3'(mq.size()) || (m_ov && (out_result !== m_res || out_opcode !== m_op))) begin
        n_bad++; $display("FAIL full_drain[%0d] got v=%b r=%h op=%b cnt=%0d want v=%b r=%h op=%b cnt=%0d",
                          i, out_valid, out_result, out_opcode, count, m_ov, m_res, m_op, mq.size());
      end
    end
  endtask

  task automatic test_mixed();
    logic acc;
    logic [7:0] av [4] = '{8'd5, 8'd5, 8'd5, 8'd3};
    logic [7:0] bv [4] = '{8'd3, 8'd3, 8'd3, 8'd5};
    logic [1:0] ov [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [7:0] rv [4] = '{8'h02, 8'h07, 8'h06, 8'hFE};
    int got = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) cycle(1'b1, av[i], bv[i], ov[i], 1'b1, 1'b0, acc);
      else       cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, acc);
      if (out_valid === 1'b1 && got < 4) begin
        n_vec++;
        if (out_result !== rv[got] || out_opcode !== ov[got]) begin
          n_bad++; $display("FAIL mixed[%0d] got r=%h op=%b want r=%h op=%b", got, out_result, out_opcode, rv[got], ov[got]);
        end
        got++;
      end
    end
    n_vec++; if (got != 4) begin n_bad++; $display("FAIL mixed_count got %0d want 4", got); end
  endtask

  task automatic test_stream();
    logic acc;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, 1'b0, acc);
      n_vec++; if (count !== 3'd1) begin n_bad++; $display("FAIL stream_count[%0d] got %0d want 1", i, count); end
      if (i > 0) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_result !== m_res || out_opcode !== m_op) begin
          n_bad++; $display("FAIL stream_result[%0d] got v=%b r=%h op=%b want v=1 r=%h op=%b", i, out_valid, out_result, out_opcode, m_res, m_op);
        end
      end
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, acc);
    n_vec++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain got cnt=%0d v=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_mid_reset();
    logic acc;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, 1'b0, acc);
    n_vec++; if (count !== 3'd3 || out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre got cnt=%0d v=%b want 3/1", count, out_valid); end
    cycle(1'b1, 8'h12, 8'h34, 2'b00, 1'b1, 1'b1, acc);
    n_vec++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 8'h00) begin
      n_bad++; $display("FAIL midrst_post got cnt=%0d v=%b rdy=%b r=%h want 0/0/1/00", count, out_valid, in_ready, out_result);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, acc);
      n_vec++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_bad++; $display("FAIL midrst_stale[%0d] got v=%b cnt=%0d want 0/0", i, out_valid, count); end
    end
  endtask

  task automatic test_random();
    logic acc;
    for (int i = 0; i < 300; i++) begin
      n_vec++; if (in_ready !== (mq.size() < DEPTH)) begin n_bad++; $display("FAIL rand_in_ready[%0d] got %b want %b", i, in_ready, mq.size() < DEPTH); end
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 2'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0), acc);
      n_vec++;
      if (out_valid !== m_ov || out_result !== m_res || out_opcode !== m_op || count !== 3'(mq.size())) begin
        n_bad++; $display("FAIL rand_state[%0d] got v=%b r=%h op=%b cnt=%0d want v=%b r=%h op=%b cnt=%0d",
                          i, out_valid, out_result, out_opcode, count, m_ov, m_res, m_op, mq.size());
      end
      n_vec++;
      if (mq.size() == 0) begin
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_opcode !== 2'b00) begin
          n_bad++; $display("FAIL rand_head_empty[%0d] got %h/%h/%b want 00/00/00", i, alu_a, alu_b, alu_opcode);
        end
      end else if (alu_a !== mq[0].a || alu_b !== mq[0].b || alu_opcode !== mq[0].op) begin
        n_bad++; $display("FAIL rand_head[%0d] got %h/%h/%b want %h/%h/%b", i, alu_a, alu_b, alu_opcode, mq[0].a, mq[0].b, mq[0].op);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_add();
    test_full();
    test_mixed();
    test_stream();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_queue.md
Name: alu_cmd_queue

Overview:
- Issue stage directly upstream of the combinational N-bit ALU (2-bit opcode: 00 add, 10 sub, 01 or, other xor).
- Buffers operand/opcode commands in a FIFO and drives the head command onto the ALU inputs.
- Captures the ALU output into a registered result stage with valid/ready handshake on both sides.
- Exactly one command is retired to the result register per cycle, at most.

Parameters:
- w, 8, operand and result width in bits; it must match the w of the attached ALU.
- DEPTH, 4, FIFO depth in commands; power of 2, ≥2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream command valid.
- in_ready  output  1  queue can accept a command this cycle.
- in_a  input  w  operand a.
- in_b  input  w  operand b.
- in_opcode  input  2  ALU opcode.
- alu_a  output  w  to ALU a: head entry operand a.
- alu_b  output  w  to ALU b: head entry operand b.
- alu_opcode  output  2  to ALU opcode: head entry opcode.
- alu_out  input  w  from ALU out.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  downstream accepts the result.
- out_result  output  w  registered ALU result.
- out_opcode  output  2  opcode that produced out_result.
- count  output  $clog2(DEPTH)+1  number of commands currently queued (excludes the result register).

Behaviour:
- Reset is synchronous, active-high, single clock clk.
  - On a rst edge: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_result=0, out_opcode=0.
  - Queued commands and any held result are discarded, including mid-operation.
  - FIFO storage contents are don't-care.
  - rst has priority over every push and pop in the same cycle.
- in_ready = (count != DEPTH). It is purely registered state; there is no combinational path from out_ready.
- Push: in_valid && in_ready at an edge. The entry is written at wr_ptr, wr_ptr increments modulo DEPTH, count increments.
- Head drive, combinational from FIFO state:
  - alu_a/alu_b/alu_opcode = entry at rd_ptr when count>0.
  - All zero when count==0.
- Result register free: free = !out_valid || out_ready.
- Pop: count>0 && free at an edge.
  - out_result <= alu_out.
  - out_opcode <= head opcode.
  - out_valid <= 1.
  - rd_ptr increments modulo DEPTH; count decrements.
- If out_valid && out_ready && count==0 at an edge, out_valid <= 0. out_result and out_opcode hold their last value.
- If out_valid && !out_ready, out_result and out_opcode are stable and out_valid stays 1. No pop occurs.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - Legal at any count including DEPTH-1.
  - At count==DEPTH, push is blocked even if a pop occurs that cycle.
- Push into an empty queue: there is no fall-through. The command is popped no earlier than the following edge.
- Minimum latency: command accepted at edge N gives out_valid=1 after edge N+1 with the result for that command.
- Throughput: 1 result/cycle sustained when out_ready=1 and the queue is non-empty.
- Arithmetic is performed by the ALU. Expected results, all modulo 2^w:
  - 00: a+b.
  - 10: a-b.
  - 01: a|b.
  - other: a^b.
- Ordering: results leave strictly in command acceptance order.
- Pointer wrap: pointers are $clog2(DEPTH) bits wide and wrap naturally. count distinguishes full from empty.

Test Plan (w=8, DEPTH=4, real ALU instance attached):
- Reset then idle: after a rst pulse, in_ready=1, out_valid=0, count=0, out_result=0, alu_a=alu_b=0.
- Single add: push a=8'hF0,b=8'h20,op=00 at edge N, out_ready=1 → out_valid=1 after edge N+1, out_result=8'h10 (wrap), out_opcode=00; out_valid=0 after edge N+2.
- Backpressure/full: out_ready=0, push 5 commands back-to-back.
  - Expected: first retires to the result register, next 4 fill the FIFO (count=4), in_ready=0. The 6th push is refused.
  - Release out_ready → results drain in order, one per cycle.
- Mixed opcodes in order: push (5,3,10),(5,3,01),(5,3,11),(3,5,10) → out_result sequence 8'h02, 8'h07, 8'h06, 8'hFE with matching out_opcode.
- Streaming with simultaneous push/pop: continuous in_valid with out_ready=1 for 10 cycles → count stays 1, one result per cycle, and pointers wrap past DEPTH without loss.
- Reset mid-operation: with count=3 and out_valid=1, assert rst for one edge → count=0, out_valid=0, in_ready=1. No stale result appears afterwards.
